// File: rtl/avalon_pio_capture_if.sv
// avalon_pio_capture_if
//   Avalon-MM slave bus bundle for avalon_pio_capture.
//   address   [3:0]  word address
//   write            single-cycle write strobe, no wait states
//   writedata [31:0] write data
//   readdata  [31:0] registered read data (1-cycle latency, no read strobe)
//   irq              registered level interrupt
interface avalon_pio_capture_if;
  logic [3:0]  address;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (output address, write, writedata, input readdata, irq);
  modport slave  (input address, write, writedata, output readdata, irq);
endinterface

// File: rtl/avalon_pio_capture.sv
// avalon_pio_capture
//   Multi-channel Avalon-MM input PIO. Each WIDTH-bit channel is synchronised,
//   edge-detected into sticky W1C capture bits and gated by a per-channel mask
//   into one registered level interrupt.
//   clk      sole clock
//   reset_n  asynchronous active-low reset
//   bus      avalon_pio_capture_if.slave (address/write/writedata/readdata/irq)
//   in_port  N_CH*WIDTH fabric inputs, channel c at [c*WIDTH +: WIDTH], async
//   Map: 0+c data (RO), 4+c edge (W1C), 8+c mask (RW), 12 pending (RO).

// Per-channel slice: synchroniser, previous-value register, edge capture, mask.
module avalon_pio_capture_ch #(
  parameter int WIDTH       = 32,
  parameter int EDGE_MODE   = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             prime,
  input  logic [WIDTH-1:0] in_bits,
  input  logic             clr_we,
  input  logic             mask_we,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] sync_o,
  output logic [WIDTH-1:0] edge_o,
  output logic [WIDTH-1:0] mask_o
);
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] prev_q, edge_q, mask_q, det, clr;

  assign sync_o = sync_q[SYNC_STAGES-1];
  assign edge_o = edge_q;
  assign mask_o = mask_q;

  // Until primed, prev is still catching up with the synchroniser output,
  // so any apparent edge is an artefact of the reset zeros.
  always_comb begin
    det = '0;
    clr = clr_we ? wdata : '0;
    if (prime) begin
      case (EDGE_MODE)
        0:       det = sync_o & ~prev_q;
        1:       det = ~sync_o & prev_q;
        default: det = sync_o ^ prev_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      prev_q <= '0;
      edge_q <= '0;
      mask_q <= '0;
    end else begin
      sync_q[0] <= in_bits;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= sync_o;
      // Clear applied first so a same-cycle edge keeps the bit set.
      edge_q <= (edge_q & ~clr) | det;
      if (mask_we) mask_q <= wdata;
    end
  end
endmodule

module avalon_pio_capture #(
  parameter int WIDTH       = 32,
  parameter int N_CH        = 4,
  parameter int EDGE_MODE   = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  avalon_pio_capture_if.slave    bus,
  input  logic [N_CH*WIDTH-1:0]  in_port
);
  localparam int CW = $clog2(SYNC_STAGES + 1);

  logic [N_CH-1:0][WIDTH-1:0] sync_a, edge_a, mask_a;
  logic [N_CH-1:0]            pend;
  logic                       prime_q;
  logic [CW-1:0]              fill_q;
  logic [31:0]                rd_nxt, rd_q;
  logic                       irq_q;

  // Prime rises SYNC_STAGES+1 clocks after reset release: the synchroniser is
  // full after SYNC_STAGES clocks and prev needs one more to match it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fill_q  <= '0;
      prime_q <= 1'b0;
    end else if (!prime_q) begin
      if (fill_q == CW'(SYNC_STAGES)) prime_q <= 1'b1;
      else                            fill_q  <= fill_q + CW'(1);
    end
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    logic clr_we, mask_we;
    // Only existing channels decode; writes to absent ones fall through.
    assign clr_we  = bus.write && (bus.address == 4'(4 + c));
    assign mask_we = bus.write && (bus.address == 4'(8 + c));

    avalon_pio_capture_ch #(
      .WIDTH(WIDTH), .EDGE_MODE(EDGE_MODE), .SYNC_STAGES(SYNC_STAGES)
    ) u_ch (
      .clk     (clk),
      .reset_n (reset_n),
      .prime   (prime_q),
      .in_bits (in_port[c*WIDTH +: WIDTH]),
      .clr_we  (clr_we),
      .mask_we (mask_we),
      .wdata   (bus.writedata[WIDTH-1:0]),
      .sync_o  (sync_a[c]),
      .edge_o  (edge_a[c]),
      .mask_o  (mask_a[c])
    );

    assign pend[c] = |(edge_a[c] & mask_a[c]);
  end

  // Unmapped addresses, absent channels and bits above WIDTH read zero.
  always_comb begin
    rd_nxt = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (bus.address == 4'(c))     rd_nxt = 32'(sync_a[c]);
      if (bus.address == 4'(4 + c)) rd_nxt = 32'(edge_a[c]);
      if (bus.address == 4'(8 + c)) rd_nxt = 32'(mask_a[c]);
    end
    if (bus.address == 4'd12) rd_nxt = 32'(pend);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_q  <= '0;
      irq_q <= 1'b0;
    end else begin
      rd_q  <= rd_nxt;
      irq_q <= |pend;
    end
  end

  assign bus.readdata = rd_q;
  assign bus.irq      = irq_q;
endmodule
